// File: rtl/player_collision_ctl_if.sv
// ============================================================================
// Module  : player_collision_ctl_if
// Purpose : Collision probe bus between the player controller and map ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface player_collision_ctl_if;
  logic [15:0] probe_addr_x;
  logic [15:0] probe_addr_y;
  logic [3:0]  tile_x;
  logic [3:0]  tile_y;

  modport master (
    output probe_addr_x,
    output probe_addr_y,
    input  tile_x,
    input  tile_y
  );

  modport slave (
    input  probe_addr_x,
    input  probe_addr_y,
    output tile_x,
    output tile_y
  );
endinterface

`default_nettype wire

// File: rtl/player_collision_ctl.sv
// ============================================================================
// Module  : player_collision_ctl
// Purpose : Per-frame player movement with map collision, gravity and jump.
//           Optional goal tile support is enabled by PLAYER_COLL_GOAL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module player_collision_ctl #(
  parameter logic [7:0] X_INIT   = 8'd16,
  parameter logic [7:0] Y_INIT   = 8'd16,
  parameter int         JUMP_V   = 6,
  parameter int         MAX_FALL = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               frame_tick,
  input  wire logic               btn_left,
  input  wire logic               btn_right,
  input  wire logic               btn_jump,
  player_collision_ctl_if.master  rom,
  output logic [7:0]              xpos,
  output logic [7:0]              ypos,
  output logic                    grounded,
  output logic                    busy,
  output logic                    goal_reached
);

  localparam logic signed [4:0] c_jump_vel = 5'(-JUMP_V);
  localparam logic signed [4:0] c_max_fall = 5'(MAX_FALL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_H_WAIT  = 3'd1,
    S_H_CHK   = 3'd2,
    S_V_SETUP = 3'd3,
    S_V_WAIT  = 3'd4,
    S_V_CHK   = 3'd5
  } state_t;

  state_t             r_state,    w_state;
  logic [7:0]         r_xpos,     w_xpos;
  logic [7:0]         r_ypos,     w_ypos;
  logic signed [4:0]  r_vel,      w_vel;
  logic [4:0]         r_steps,    w_steps;
  logic               r_grounded, w_grounded;
  logic               r_busy,     w_busy;
  logic               r_left,     w_left;
  logic               r_right,    w_right;
  logic               r_jump,     w_jump;
  logic [15:0]        r_probe_x,  w_probe_x;
  logic [15:0]        r_probe_y,  w_probe_y;

  logic               w_tile_x_free;
  logic               w_tile_y_free;
  logic               w_launch;
  logic               w_launch_up;
  logic [7:0]         w_launch_y;

`ifdef PLAYER_COLL_GOAL_EN
  logic               r_goal, w_goal;
  // The goal tile is passable; reaching it only raises the sticky flag.
  assign w_tile_x_free = (rom.tile_x == 4'h0) || (rom.tile_x == 4'hF);
  assign w_tile_y_free = (rom.tile_y == 4'h0) || (rom.tile_y == 4'hF);
  assign goal_reached  = r_goal;
`else
  assign w_tile_x_free = (rom.tile_x == 4'h0);
  assign w_tile_y_free = (rom.tile_y == 4'h0);
  assign goal_reached  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_xpos     <= X_INIT;
      r_ypos     <= Y_INIT;
      r_vel      <= '0;
      r_steps    <= '0;
      r_grounded <= 1'b0;
      r_busy     <= 1'b0;
      r_left     <= 1'b0;
      r_right    <= 1'b0;
      r_jump     <= 1'b0;
      r_probe_x  <= {Y_INIT, X_INIT};
      r_probe_y  <= {Y_INIT, X_INIT};
`ifdef PLAYER_COLL_GOAL_EN
      r_goal     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_xpos     <= w_xpos;
      r_ypos     <= w_ypos;
      r_vel      <= w_vel;
      r_steps    <= w_steps;
      r_grounded <= w_grounded;
      r_busy     <= w_busy;
      r_left     <= w_left;
      r_right    <= w_right;
      r_jump     <= w_jump;
      r_probe_x  <= w_probe_x;
      r_probe_y  <= w_probe_y;
`ifdef PLAYER_COLL_GOAL_EN
      r_goal     <= w_goal;
`endif
    end
  end

  always_comb begin
    w_state     = r_state;
    w_xpos      = r_xpos;
    w_ypos      = r_ypos;
    w_vel       = r_vel;
    w_steps     = r_steps;
    w_grounded  = r_grounded;
    w_busy      = r_busy;
    w_left      = r_left;
    w_right     = r_right;
    w_jump      = r_jump;
    w_probe_x   = r_probe_x;
    w_probe_y   = r_probe_y;
    w_launch    = 1'b0;
    w_launch_up = r_vel[4];
    w_launch_y  = r_ypos;
`ifdef PLAYER_COLL_GOAL_EN
    w_goal      = r_goal;
`endif

    case (r_state)
      S_IDLE: begin
        if (frame_tick) begin
          w_busy  = 1'b1;
          w_left  = btn_left & ~btn_right;
          w_right = btn_right & ~btn_left;
          w_jump  = btn_jump;
          if (btn_right && !btn_left && r_xpos != 8'hFF) begin
            w_probe_x = {r_ypos, r_xpos + 8'd1};
            w_state   = S_H_WAIT;
          end else if (btn_left && !btn_right && r_xpos != 8'h00) begin
            w_probe_x = {r_ypos, r_xpos - 8'd1};
            w_state   = S_H_WAIT;
          end else begin
            w_state   = S_V_SETUP;
          end
        end
      end

      S_H_WAIT: w_state = S_H_CHK;

      S_H_CHK: begin
        // The probe column already holds xpos+dx.
        if (w_tile_x_free) w_xpos = r_probe_x[7:0];
`ifdef PLAYER_COLL_GOAL_EN
        if (rom.tile_x == 4'hF) w_goal = 1'b1;
`endif
        w_state = S_V_SETUP;
      end

      S_V_SETUP: begin
        w_grounded = 1'b0;
        if (r_jump && r_grounded)   w_vel = c_jump_vel;
        else if (r_vel >= c_max_fall) w_vel = c_max_fall;
        else                        w_vel = r_vel + 5'sd1;
        w_steps = w_vel[4] ? $unsigned(-w_vel) : $unsigned(w_vel);
        if (w_steps == 5'd0) begin
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_launch    = 1'b1;
          w_launch_up = w_vel[4];
          w_launch_y  = r_ypos;
        end
      end

      S_V_WAIT: w_state = S_V_CHK;

      S_V_CHK: begin
`ifdef PLAYER_COLL_GOAL_EN
        if (rom.tile_y == 4'hF) w_goal = 1'b1;
`endif
        if (w_tile_y_free) begin
          w_ypos  = r_probe_y[15:8];
          w_steps = r_steps - 5'd1;
          if (w_steps == 5'd0) begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end else begin
            w_launch    = 1'b1;
            w_launch_up = r_vel[4];
            w_launch_y  = r_probe_y[15:8];
          end
        end else begin
          w_vel = '0;
          if (!r_vel[4]) w_grounded = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end

      default: begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
    endcase

    // Next vertical step: the map border acts as a solid tile without a probe.
    if (w_launch) begin
      if (w_launch_up ? (w_launch_y == 8'h00) : (w_launch_y == 8'hFF)) begin
        w_vel = '0;
        if (!w_launch_up) w_grounded = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end else begin
        w_probe_y = {(w_launch_up ? w_launch_y - 8'd1 : w_launch_y + 8'd1), w_xpos};
        w_state   = S_V_WAIT;
      end
    end
  end

  assign rom.probe_addr_x = r_probe_x;
  assign rom.probe_addr_y = r_probe_y;
  assign xpos             = r_xpos;
  assign ypos             = r_ypos;
  assign grounded         = r_grounded;
  assign busy             = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_player_collision_ctl.sv
// ============================================================================
// Module  : tb_player_collision_ctl
// Purpose : Self-checking bench with a registered collision ROM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_collision_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_jump = 1'b0;
  logic [7:0] xpos, ypos;
  logic       grounded, busy, goal_reached;

  int         errors = 0;
  int         checks = 0;

  // Map: rows at or below floor_y are solid; column wall_x returns wall_code.
  int         floor_y = 21;
  int         wall_x = 0;
  logic [3:0] wall_code = 4'h0;

`ifdef PLAYER_COLL_GOAL_EN
  localparam int   XG   = 18;
  localparam logic GOAL = 1'b1;
`else
  localparam int   XG   = 17;
  localparam logic GOAL = 1'b0;
`endif

  player_collision_ctl_if bus ();

  player_collision_ctl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_jump     (btn_jump),
    .rom          (bus),
    .xpos         (xpos),
    .ypos         (ypos),
    .grounded     (grounded),
    .busy         (busy),
    .goal_reached (goal_reached)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] tile_of(input logic [15:0] a);
    if (int'(a[15:8]) >= floor_y) return 4'h1;
    if (int'(a[7:0]) == wall_x)   return wall_code;
    return 4'h0;
  endfunction

  always @(posedge clk) begin
    bus.tile_x <= tile_of(bus.probe_addr_x);
    bus.tile_y <= tile_of(bus.probe_addr_y);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: tick is sampled on the first edge; lat counts edges to busy low.
  task automatic run_frame(input logic l, input logic r, input logic j,
                           input logic extra, output int lat);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    lat = 1;
    while (busy && lat < 40) begin
      if (extra && lat == 1) frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      lat++;
    end
    if (busy) chk("frame_timeout", 1, 0);
  endtask

  typedef struct {
    int         floor_y;
    int         wall_x;
    logic [3:0] wall_code;
    logic       l, r, j;
    int         ex, ey;
    logic       eg, egoal;
    int         elat;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int lat;
    int frames;
    logic [15:0] saved;

    tbl[0]  = '{21,  0, 4'h0, 0, 0, 0, 16,   17, 0, 0,    4};
    tbl[1]  = '{21,  0, 4'h0, 0, 0, 0, 16,   19, 0, 0,    6};
    tbl[2]  = '{21,  0, 4'h0, 0, 0, 0, 16,   20, 1, 0,    6};
    tbl[3]  = '{21,  0, 4'h0, 0, 0, 0, 16,   20, 1, 0,    4};
    tbl[4]  = '{21,  0, 4'h0, 0, 0, 0, 16,   20, 1, 0,    4};
    tbl[5]  = '{21,  0, 4'h0, 0, 0, 0, 16,   20, 1, 0,    4};
    tbl[6]  = '{21, 17, 4'h1, 0, 1, 0, 16,   20, 1, 0,    6};
    tbl[7]  = '{21,  0, 4'h0, 0, 1, 0, 17,   20, 1, 0,    6};
    tbl[8]  = '{21, 16, 4'h5, 1, 0, 0, 17,   20, 1, 0,    6};
    tbl[9]  = '{21,  0, 4'h0, 1, 1, 0, 17,   20, 1, 0,    4};
    tbl[10] = '{21, 18, 4'hF, 0, 1, 0, XG,   20, 1, GOAL, 6};
    tbl[11] = '{21,  0, 4'h0, 0, 0, 1, XG,   14, 0, GOAL, 14};
    tbl[12] = '{21,  0, 4'h0, 0, 0, 0, XG,    9, 0, GOAL, 12};
    tbl[13] = '{21,  0, 4'h0, 0, 0, 1, XG,    5, 0, GOAL, 10};
    tbl[14] = '{21,  0, 4'h0, 0, 0, 0, XG,    2, 0, GOAL, 8};
    tbl[15] = '{21,  0, 4'h0, 0, 0, 0, XG,    0, 0, GOAL, 6};
    tbl[16] = '{21,  0, 4'h0, 0, 0, 0, XG,    0, 0, GOAL, 2};
    tbl[17] = '{21,  0, 4'h0, 0, 1, 0, XG+1,  1, 0, GOAL, 6};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_xpos", xpos, 16);
    chk("rst_ypos", ypos, 16);
    chk("rst_grounded", grounded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_goal", goal_reached, 0);
    chk("rst_probe_x", bus.probe_addr_x, 16'h1010);
    chk("rst_probe_y", bus.probe_addr_y, 16'h1010);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_xpos", xpos, 16);
    chk("idle_busy", busy, 0);
    chk("idle_probe_y", bus.probe_addr_y, 16'h1010);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      floor_y = tbl[i].floor_y; wall_x = tbl[i].wall_x; wall_code = tbl[i].wall_code;
      run_frame(tbl[i].l, tbl[i].r, tbl[i].j, 1'b0, lat);
      chk($sformatf("vec%0d_xpos", i), xpos, tbl[i].ex);
      chk($sformatf("vec%0d_ypos", i), ypos, tbl[i].ey);
      chk($sformatf("vec%0d_grounded", i), grounded, tbl[i].eg);
      chk($sformatf("vec%0d_goal", i), goal_reached, tbl[i].egoal);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].elat);
    end

    // Extra tick while busy must not start a second update.
    floor_y = 256;
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, lat);
    chk("ignore_latency", lat, 6);
    chk("ignore_ypos", ypos, 3);
    frames = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy) frames++;
    end
    chk("ignore_no_restart", frames, 0);
    chk("ignore_ypos_after", ypos, 3);

    // Free fall to the bottom border.
    frames = 0;
    while (!grounded && frames < 100) begin
      run_frame(1'b0, 1'b0, 1'b0, 1'b0, lat);
      frames++;
    end
    chk("fall_bounded", int'(frames < 100), 1);
    chk("bottom_ypos", ypos, 255);
    chk("bottom_grounded", grounded, 1);
    saved = bus.probe_addr_y;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, lat);
    chk("bottom_latency", lat, 2);
    chk("bottom_grounded2", grounded, 1);
    chk("bottom_no_probe", bus.probe_addr_y, saved);

    // Reset in the middle of a jump.
    @(negedge clk);
    btn_jump = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_xpos", xpos, 16);
    chk("midrst_ypos", ypos, 16);
    chk("midrst_busy", busy, 0);
    chk("midrst_grounded", grounded, 0);
    chk("midrst_goal", goal_reached, 0);
    chk("midrst_probe_x", bus.probe_addr_x, 16'h1010);
    chk("midrst_probe_y", bus.probe_addr_y, 16'h1010);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; btn_jump = 1'b0;

    // Walk to the left border standing on a floor at row 17.
    floor_y = 17; wall_code = 4'h0;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, lat);
    chk("land_ypos", ypos, 16);
    chk("land_grounded", grounded, 1);
    chk("land_latency", lat, 4);
    for (int k = 15; k >= 0; k--) begin
      run_frame(1'b1, 1'b0, 1'b0, 1'b0, lat);
      chk($sformatf("walk_x%0d", k), xpos, k);
      chk($sformatf("walk_lat%0d", k), lat, 6);
    end
    saved = bus.probe_addr_x;
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, lat);
    chk("left_edge_xpos", xpos, 0);
    chk("left_edge_latency", lat, 4);
    chk("left_edge_no_probe", bus.probe_addr_x, saved);
    chk("left_edge_ypos", ypos, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
